// File: rtl/edge_event_detector_if.sv
// Bundle of the per-channel input-conditioner signals.
//   master : the side that drives raw pins and per-channel config
//            (signal_in, edge_mode, repeat_en); it receives the conditioned
//            outputs (level_out, rise_pulse, fall_pulse, event_pulse).
//   slave  : the conditioner itself.
// edge_mode packs 2 bits per channel in [2i+1:2i]:
//   00 rise, 01 fall, 10 both, 11 events off.
interface edge_event_detector_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   signal_in;
    logic [2*CHANNELS-1:0] edge_mode;
    logic [CHANNELS-1:0]   repeat_en;
    logic [CHANNELS-1:0]   level_out;
    logic [CHANNELS-1:0]   rise_pulse;
    logic [CHANNELS-1:0]   fall_pulse;
    logic [CHANNELS-1:0]   event_pulse;

    modport master (
        output signal_in, edge_mode, repeat_en,
        input  level_out, rise_pulse, fall_pulse, event_pulse
    );

    modport slave (
        input  signal_in, edge_mode, repeat_en,
        output level_out, rise_pulse, fall_pulse, event_pulse
    );
endinterface

// File: rtl/edge_event_detector.sv
// Multi-channel button/switch conditioner.
// Each channel synchronises its raw pin through 2 flops, debounces it
// (DEBOUNCE_CYCLES consecutive differing samples accept a new level),
// emits registered rise/fall pulses, and a mode-selected event pulse that
// can also carry hold-to-auto-repeat ticks.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset; clears every flop
//   bus      edge_event_detector_if.slave (signal_in, edge_mode, repeat_en in;
//            level_out, rise_pulse, fall_pulse, event_pulse out)
// All outputs are registered.

module eed_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_i,
    input  logic [1:0] mode_i,
    input  logic       rep_en_i,
    output logic       level_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic       event_o
);
    // A parameter of 1 still needs a 1-bit counter.
    localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RDW = (REPEAT_DELAY    > 1) ? $clog2(REPEAT_DELAY)    : 1;
    localparam int RPW = (REPEAT_PERIOD   > 1) ? $clog2(REPEAT_PERIOD)   : 1;
    localparam int RW  = (RDW > RPW) ? RDW : RPW;

    localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RDL_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPR_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          rise_q, fall_q, event_q;
    logic          rise_d, fall_d;
    logic          edge_sel;
    logic          tick_allow;
    logic [RW-1:0] rcnt_q;
    rpt_state_t    state_q;

    // Debounce: any sample matching the current level restarts the window.
    // The >= compare makes the counter stop at its terminal value even if
    // it were ever disturbed, instead of wrapping.
    always_comb begin
        level_d = level_q;
        dcnt_d  = dcnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q >= D_LAST) begin
            level_d = ~level_q;
            dcnt_d  = '0;
            rise_d  = ~level_q;
            fall_d  = level_q;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    always_comb begin
        edge_sel = 1'b0;
        unique case (mode_i)
            2'b00:   edge_sel = rise_d;
            2'b01:   edge_sel = fall_d;
            2'b10:   edge_sel = rise_d | fall_d;
            default: edge_sel = 1'b0;
        endcase
    end

    // Ticks are muted in mode 11 but the repeat timer keeps running.
    assign tick_allow = (mode_i != 2'b11);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            dcnt_q  <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Auto-repeat FSM. event_q is written here so an edge and a tick in the
    // same cycle merge into a single pulse. A fall (or repeat_en dropping)
    // wins over a tick due in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
            event_q <= 1'b0;
        end else begin
            event_q <= edge_sel;
            if (fall_d || !rep_en_i) begin
                state_q <= RPT_IDLE;
                rcnt_q  <= '0;
            end else begin
                unique case (state_q)
                    RPT_IDLE: begin
                        if (rise_d) begin
                            state_q <= RPT_DELAY;
                            rcnt_q  <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (rcnt_q >= RDL_LAST) begin
                            state_q <= RPT_REPEAT;
                            rcnt_q  <= '0;
                            event_q <= edge_sel | tick_allow;
                        end else begin
                            rcnt_q <= rcnt_q + RW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (rcnt_q >= RPR_LAST) begin
                            rcnt_q  <= '0;
                            event_q <= edge_sel | tick_allow;
                        end else begin
                            rcnt_q <= rcnt_q + RW'(1);
                        end
                    end
                    default: begin
                        state_q <= RPT_IDLE;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = event_q;
endmodule

module edge_event_detector #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    edge_event_detector_if.slave  bus
);
    logic [CHANNELS-1:0] level_w, rise_w, fall_w, event_w;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        eed_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (bus.signal_in[g]),
            .mode_i   (bus.edge_mode[2*g+1:2*g]),
            .rep_en_i (bus.repeat_en[g]),
            .level_o  (level_w[g]),
            .rise_o   (rise_w[g]),
            .fall_o   (fall_w[g]),
            .event_o  (event_w[g])
        );
    end

    assign bus.level_out   = level_w;
    assign bus.rise_pulse  = rise_w;
    assign bus.fall_pulse  = fall_w;
    assign bus.event_pulse = event_w;
endmodule

// File: tb/tb_edge_event_detector.sv
// Directed bench for edge_event_detector with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3, CHANNELS=4. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point, so the loop
// index e means "just after clock edge e" counted from the stimulus change.
module tb_edge_event_detector;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    edge_event_detector_if #(.CHANNELS(4)) bus ();

    edge_event_detector #(
        .CHANNELS        (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        bus.signal_in = 4'hF;
        bus.edge_mode = 8'h00;
        bus.repeat_en = 4'h0;
        reset_n = 1'b0;
        idle(3);
        total++; if (bus.level_out !== 4'h0) begin bad++; $display("FAIL rst_level got=%h exp=0", bus.level_out); end
        total++; if (bus.rise_pulse !== 4'h0) begin bad++; $display("FAIL rst_rise got=%h exp=0", bus.rise_pulse); end
        total++; if (bus.fall_pulse !== 4'h0) begin bad++; $display("FAIL rst_fall got=%h exp=0", bus.fall_pulse); end
        total++; if (bus.event_pulse !== 4'h0) begin bad++; $display("FAIL rst_event got=%h exp=0", bus.event_pulse); end
        reset_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            exp = (e == 5) ? 4'hF : 4'h0;
            total++; if (bus.rise_pulse !== exp) begin bad++; $display("FAIL post_rst_rise e=%0d got=%h exp=%h", e, bus.rise_pulse, exp); end
            exp = (e >= 5) ? 4'hF : 4'h0;
            total++; if (bus.level_out !== exp) begin bad++; $display("FAIL post_rst_level e=%0d got=%h exp=%h", e, bus.level_out, exp); end
        end
        bus.signal_in = 4'h0;
        idle(12);
    endtask

    task automatic test_glitch();
        bus.signal_in = 4'b0001;
        for (int e = 0; e <= 9; e++) begin
            step();
            if (e == 2) bus.signal_in = 4'h0;
            total++; if (bus.level_out[0] !== 1'b0) begin bad++; $display("FAIL glitch_level e=%0d got=%b exp=0", e, bus.level_out[0]); end
            total++; if (bus.rise_pulse[0] !== 1'b0) begin bad++; $display("FAIL glitch_rise e=%0d got=%b exp=0", e, bus.rise_pulse[0]); end
            total++; if (bus.event_pulse[0] !== 1'b0) begin bad++; $display("FAIL glitch_event e=%0d got=%b exp=0", e, bus.event_pulse[0]); end
        end
        idle(4);
        bus.signal_in = 4'b0001;
        for (int e = 0; e <= 12; e++) begin
            step();
            if (e == 3) bus.signal_in = 4'h0;
            total++; if (bus.rise_pulse[0] !== (e == 5)) begin bad++; $display("FAIL win4_rise e=%0d got=%b exp=%b", e, bus.rise_pulse[0], (e == 5)); end
            total++; if (bus.level_out[0] !== (e >= 5 && e < 9)) begin bad++; $display("FAIL win4_level e=%0d got=%b exp=%b", e, bus.level_out[0], (e >= 5 && e < 9)); end
            total++; if (bus.fall_pulse[0] !== (e == 9)) begin bad++; $display("FAIL win4_fall e=%0d got=%b exp=%b", e, bus.fall_pulse[0], (e == 9)); end
            total++; if (bus.event_pulse[0] !== (e == 5)) begin bad++; $display("FAIL win4_event e=%0d got=%b exp=%b", e, bus.event_pulse[0], (e == 5)); end
        end
        idle(4);
    endtask

    task automatic test_modes();
        logic [3:0] er, ef, ev;
        bus.edge_mode = 8'b11_10_01_00;
        bus.signal_in = 4'b1110;
        for (int e = 0; e <= 12; e++) begin
            step();
            if (e == 3) bus.signal_in = 4'h0;
            er = (e == 5) ? 4'b1110 : 4'b0000;
            ef = (e == 9) ? 4'b1110 : 4'b0000;
            ev = (e == 5) ? 4'b0100 : (e == 9) ? 4'b0110 : 4'b0000;
            total++; if (bus.rise_pulse !== er) begin bad++; $display("FAIL mode_rise e=%0d got=%h exp=%h", e, bus.rise_pulse, er); end
            total++; if (bus.fall_pulse !== ef) begin bad++; $display("FAIL mode_fall e=%0d got=%h exp=%h", e, bus.fall_pulse, ef); end
            total++; if (bus.event_pulse !== ev) begin bad++; $display("FAIL mode_event e=%0d got=%h exp=%h", e, bus.event_pulse, ev); end
        end
        bus.edge_mode = 8'h00;
        idle(4);
    endtask

    task automatic test_repeat();
        logic [3:0] ev;
        bus.repeat_en = 4'b0001;
        bus.signal_in = 4'b0001;
        // Rise at 5, first tick 10 later, then every 3; release makes the fall
        // land at 45, where a tick would also be due and must lose.
        for (int e = 0; e <= 50; e++) begin
            step();
            if (e == 39) bus.signal_in = 4'h0;
            ev = {3'b000, (e == 5) || (e >= 15 && e <= 42 && ((e - 15) % 3) == 0)};
            total++; if (bus.event_pulse !== ev) begin bad++; $display("FAIL rpt_event e=%0d got=%h exp=%h", e, bus.event_pulse, ev); end
            total++; if (bus.fall_pulse[0] !== (e == 45)) begin bad++; $display("FAIL rpt_fall e=%0d got=%b exp=%b", e, bus.fall_pulse[0], (e == 45)); end
        end
        idle(4);
        bus.repeat_en = 4'b0000;
        bus.signal_in = 4'b0001;
        for (int e = 0; e <= 40; e++) begin
            step();
            if (e == 29) bus.signal_in = 4'h0;
            ev = {3'b000, (e == 5)};
            total++; if (bus.event_pulse !== ev) begin bad++; $display("FAIL norpt_event e=%0d got=%h exp=%h", e, bus.event_pulse, ev); end
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        bus.repeat_en = 4'b0001;
        bus.signal_in = 4'b0001;
        idle(9);
        total++; if (bus.level_out[0] !== 1'b1) begin bad++; $display("FAIL mid_pre_level got=%b exp=1", bus.level_out[0]); end
        reset_n = 1'b0;
        #1;
        total++; if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.event_pulse} !== 16'h0) begin
            bad++; $display("FAIL mid_rst_zero got=%h exp=0", {bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.event_pulse});
        end
        step();
        step();
        reset_n = 1'b1;
        // Repeat must restart from a fresh press: rise at 5, first tick at 15.
        for (int e = 0; e <= 16; e++) begin
            step();
            total++; if (bus.rise_pulse[0] !== (e == 5)) begin bad++; $display("FAIL mid_rise e=%0d got=%b exp=%b", e, bus.rise_pulse[0], (e == 5)); end
            total++; if (bus.event_pulse[0] !== (e == 5 || e == 15)) begin bad++; $display("FAIL mid_event e=%0d got=%b exp=%b", e, bus.event_pulse[0], (e == 5 || e == 15)); end
        end
        bus.signal_in = 4'h0;
        idle(12);
        bus.repeat_en = 4'b0000;
        // Reset with dcnt at 2: the window must start over from zero.
        bus.signal_in = 4'b0001;
        idle(4);
        reset_n = 1'b0;
        #1;
        total++; if ({bus.level_out, bus.rise_pulse, bus.event_pulse} !== 12'h0) begin
            bad++; $display("FAIL dcnt_rst_zero got=%h exp=0", {bus.level_out, bus.rise_pulse, bus.event_pulse});
        end
        step();
        reset_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            total++; if (bus.rise_pulse[0] !== (e == 5)) begin bad++; $display("FAIL dcnt_rise e=%0d got=%b exp=%b", e, bus.rise_pulse[0], (e == 5)); end
            total++; if (bus.level_out[0] !== (e >= 5)) begin bad++; $display("FAIL dcnt_level e=%0d got=%b exp=%b", e, bus.level_out[0], (e >= 5)); end
        end
        bus.signal_in = 4'h0;
        idle(10);
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp;
        bus.repeat_en = 4'h0;
        bus.edge_mode = 8'h00;
        bus.signal_in = 4'hF;
        for (int e = 0; e <= 8; e++) begin
            step();
            exp = (e == 5) ? 4'hF : 4'h0;
            total++; if (bus.rise_pulse !== exp) begin bad++; $display("FAIL sim_rise e=%0d got=%h exp=%h", e, bus.rise_pulse, exp); end
            total++; if (bus.event_pulse !== exp) begin bad++; $display("FAIL sim_event e=%0d got=%h exp=%h", e, bus.event_pulse, exp); end
        end
        bus.signal_in = 4'h0;
        idle(10);
    endtask

    initial begin
        bus.signal_in = 4'h0;
        bus.edge_mode = 8'h00;
        bus.repeat_en = 4'h0;
        test_reset();
        test_glitch();
        test_modes();
        test_repeat();
        test_reset_mid();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
